// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory op codes, bus widths and
// small decode helpers used by the stage and its load extender.
package mem_stage_pkg;

  localparam int MEM_OP_W   = 4;
  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic TRUE_V  = 1'b1;
  localparam logic FALSE_V = 1'b0;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [MEM_OP_W-1:0] MEM_NOP = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_LB  = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_LH  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_LW  = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_LBU = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_LHU = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_SB  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_SH  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
    logic r;
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: r = TRUE_V;
      default:                                  r = FALSE_V;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    logic r;
    case (op)
      MEM_SB, MEM_SH, MEM_SW: r = TRUE_V;
      default:                r = FALSE_V;
    endcase
    return r;
  endfunction

  // Codes 9..15 fall through to "not a memory op".
  function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
    return is_load(op) | is_store(op);
  endfunction

  // Index of the final byte of the transfer (N-1).
  function automatic logic [1:0] last_byte(input logic [MEM_OP_W-1:0] op);
    logic [1:0] r;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: r = 2'd1;
      MEM_LW, MEM_SW:          r = 2'd3;
      default:                 r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Combinational load extender: turns the little-endian byte buffer into the
// architectural load result for the given op.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [REG_BUS_W-1:0] buf_in,
  input  logic [MEM_OP_W-1:0]  mem_op,
  output logic [REG_BUS_W-1:0] wdata
);

  // Sign/zero extension selected by op
  always_comb begin
    wdata = ZERO_WORD;
    case (mem_op)
      MEM_LB:  wdata = {{24{buf_in[7]}}, buf_in[7:0]};
      MEM_LBU: wdata = {24'h00_0000, buf_in[7:0]};
      MEM_LH:  wdata = {{16{buf_in[15]}}, buf_in[15:0]};
      MEM_LHU: wdata = {16'h0000, buf_in[15:0]};
      MEM_LW:  wdata = buf_in;
      default: wdata = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through and serialises loads/stores
// into byte transfers on the 8-bit memory-controller port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  we_in,
  input  logic [REG_ADDR_W-1:0] waddr_in,
  input  logic [REG_BUS_W-1:0]  wdata_in,
  input  logic [MEM_OP_W-1:0]   mem_op,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           store_data,
  output logic                  we_out,
  output logic [REG_ADDR_W-1:0] waddr_out,
  output logic [REG_BUS_W-1:0]  wdata_out,
  output logic                  stall_req,
  output logic                  mc_req,
  output logic                  mc_wr,
  output logic [ADDR_W-1:0]     mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic                  mc_ack,
  input  logic [7:0]            mc_rdata
);

  state_e               state_q, state_d;
  logic [1:0]           k_q, k_d;
  logic [REG_BUS_W-1:0] buf_q, buf_d;

  logic [31:0]          byte_addr_s;
  logic [7:0]           store_byte_s;
  logic [REG_BUS_W-1:0] ext_data_s;
  logic                 last_s;

  assign byte_addr_s  = mem_addr + {30'd0, k_q};
  assign store_byte_s = store_data[{k_q, 3'b000} +: 8];
  assign last_s       = (k_q == last_byte(mem_op));

  mem_stage_load_ext u_load_ext (
    .buf_in (buf_q),
    .mem_op (mem_op),
    .wdata  (ext_data_s)
  );

  // State, byte counter and load buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      buf_q   <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic; rdy low freezes everything, including ack acceptance
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_d   = buf_q;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem_op(mem_op)) begin
            state_d = ST_BUSY;
            k_d     = 2'd0;
            buf_d   = ZERO_WORD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mc_ack) begin
            if (is_load(mem_op)) begin
              buf_d[{k_q, 3'b000} +: 8] = mc_rdata;
            end else begin
              buf_d = buf_q;
            end
            if (last_s) begin
              state_d = ST_DONE;
              k_d     = 2'd0;
            end else begin
              k_d = k_q + 2'd1;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    we_out    = FALSE_V;
    waddr_out = 5'd0;
    wdata_out = ZERO_WORD;
    stall_req = FALSE_V;
    mc_req    = FALSE_V;
    mc_wr     = FALSE_V;
    mc_addr   = {ADDR_W{1'b0}};
    mc_wdata  = 8'h00;
    if (!rst) begin
      we_out = FALSE_V;
    end else begin
      case (state_q)
        ST_IDLE: begin
          waddr_out = waddr_in;
          if (is_mem_op(mem_op)) begin
            stall_req = TRUE_V;
          end else begin
            we_out    = we_in;
            wdata_out = wdata_in;
          end
        end
        ST_BUSY: begin
          stall_req = TRUE_V;
          waddr_out = waddr_in;
          mc_req    = rdy;
          mc_wr     = rdy & is_store(mem_op);
          mc_addr   = byte_addr_s[ADDR_W-1:0];
          if (is_store(mem_op)) begin
            mc_wdata = store_byte_s;
          end else begin
            mc_wdata = 8'h00;
          end
        end
        ST_DONE: begin
          waddr_out = waddr_in;
          if (is_load(mem_op)) begin
            we_out    = we_in;
            wdata_out = ext_data_s;
          end else begin
            we_out    = FALSE_V;
            wdata_out = ZERO_WORD;
          end
        end
        default: we_out = FALSE_V;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the RISC-V core; sits between the EX/MEM pipeline register and MEM_WB.
- Non-memory instructions pass straight through to MEM_WB.
- Loads and stores are serialised into byte transfers on the 8-bit memory-controller port. The pipeline is stalled until all bytes complete.
- Produces the write-back triple (we/waddr/wdata) that MEM_WB registers.

Parameters:
- ADDR_W, 32: width of mc_addr. Low ADDR_W bits of the computed byte address are driven.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes the block
- we_in  in  1  register write enable from EX/MEM
- waddr_in  in  5  destination register
- wdata_in  in  32  ALU result (pass-through value)
- mem_op  in  4  memory operation code
- mem_addr  in  32  effective byte address
- store_data  in  32  rs2 value for stores
- we_out  out  1  to MEM_WB
- waddr_out  out  5  to MEM_WB
- wdata_out  out  32  to MEM_WB
- stall_req  out  1  stall request to pipeline control
- mc_req  out  1  byte transfer request
- mc_wr  out  1  1 = write, 0 = read
- mc_addr  out  ADDR_W  byte address
- mc_wdata  out  8  write byte
- mc_ack  in  1  transfer complete this cycle
- mc_rdata  in  8  read byte; valid when mc_ack=1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, byte counter k=0, load buffer=0.
  - All outputs 0.
  - Any in-flight transfer is abandoned; mc_req drops immediately.
- Byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW. Byte order is little-endian.
- Byte k address = (mem_addr + k) mod 2^32. Misaligned accesses are legal; 0xFFFFFFFF+1 wraps to 0.
- mc_wdata = store_data[8k+7:8k].
- States:
  - IDLE:
    - mem_op=NOP: outputs are the combinational pass-through of we_in/waddr_in/wdata_in; stall_req=0.
    - mem_op≠NOP: stall_req=1 in the same cycle; we_out=0; next state is BUSY with k=0.
  - BUSY:
    - mc_req=1; mc_wr=1 for stores.
    - mc_addr and mc_wdata are driven from k.
    - stall_req=1; we_out=0.
    - On mc_ack for a load, mc_rdata is latched into buffer byte k.
    - On mc_ack with k<N-1: k←k+1 and stay in BUSY. mc_req stays high; a new byte may be acked every cycle.
    - On mc_ack with k=N-1: go to DONE.
  - DONE (exactly one cycle):
    - stall_req=0; mc_req=0; waddr_out=waddr_in.
    - Loads: we_out=we_in; wdata_out is the extended buffer.
      - LB: sign-extend byte 0. LBU: zero-extend byte 0.
      - LH: sign-extend bytes 0–1. LHU: zero-extend bytes 0–1.
      - LW: all 4 bytes.
    - Stores: we_out=0, wdata_out=0.
    - Next state is IDLE. The pipeline advances on this edge, so the same instruction is never re-issued.
- Minimum latency: N+1 cycles of stall-low-to-result with single-cycle acks; each ack delay adds 1 cycle.
- Inputs are held stable by upstream while stall_req=1. Changes during BUSY are not sampled except in DONE.
- rdy=0:
  - No state or counter update.
  - mc_req forced 0; a concurrent mc_ack is ignored.
  - Outputs hold their combinational values.
- mc_ack while mc_req=0 is ignored.
- Undefined mem_op codes (9–15) are treated as NOP.

Decomposition:
- Shared defines file holds:
  - MEM_NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
  - Mem op bus width (4).
  - Existing RegBus/RegAddrBus/True_v/False_v/ZeroWord.
- One natural sub-module, load_ext: a combinational extender taking buffer[31:0] and mem_op, returning wdata.
- FSM, counter and buffer stay in mem_stage.

Test Plan:
- NOP ALU op, we_in=1, waddr=5, wdata=0x0000ABCD -> same-cycle we_out=1, waddr_out=5, wdata_out=0x0000ABCD, stall_req=0, mc_req=0.
- LW at 0x1000; memory bytes 78,56,34,12 acked back-to-back:
  - Required: mc_addr sequence 0x1000..0x1003, stall_req high 5 cycles.
  - DONE cycle: we_out=1, wdata_out=0x12345678.
- LB then LBU at 0x20 holding 0x80 -> wdata_out 0xFFFFFF80 then 0x00000080. LH/LHU of 0x8001 -> 0xFFFF8001 / 0x00008001.
- SH, store_data=0xDEADBEEF, addr 0xFFFFFFFF:
  - Required: writes 0xEF@0xFFFFFFFF, then 0xBE@0x00000000.
  - we_out=0 in DONE.
- LW with mc_ack delayed 3 cycles per byte, plus rdy=0 for 2 cycles mid-transfer -> same result 0x12345678. During rdy=0, mc_req=0 and k does not advance.
- Reset asserted after 2 bytes of an LW acked -> all outputs 0 asynchronously. After release, state is IDLE; a following NOP passes through with stall_req=0.
